seg7_scan_decoder: RTL and testbench
====================================

// Module: seg7_scan_decoder
// PURPOSE
//  Receive side of our multiplexed 7-segment display path: samples scanned segment/anode lines,
//  decodes each stable segment pattern back to a 4-bit hex value per digit.
//  Per-digit debounce rejects ghosting during anode switching; flags illegal patterns.
//  Used for display loopback checking and for reading external scanned displays.
// PARAMETERS
//  DIGITS      4  number of scanned digits (anode lines), 1..8
//  STABLE_CNT  3  consecutive identical samples required before a digit pattern is accepted, 1..15
// PORTS
//  clk          in   1          system clock, rising edge
//  reset        in   1          asynchronous reset, active-low (asserted when 0)
//  sample_en    in   1          sample strobe; seg_in/an_in are sampled only when 1
//  seg_in       in   7          segments {a,b,c,d,e,f,g}, bit6=a, active-high
//  an_in        in   DIGITS     digit select, one-hot, active-high; bit k = digit k
//  digit_data   out  4*DIGITS   decoded values; digit k at [4k+3:4k]
//  digit_valid  out  DIGITS     bit k = digit_data for digit k holds an accepted legal value
//  frame_valid  out  1          1-cycle pulse: every digit accepted at least once since the last pulse
//  pattern_err  out  1          1-cycle pulse: a stable pattern was illegal
//  an_err       out  1          1-cycle pulse: sample_en with an_in not one-hot
// BEHAVIOUR
//  - Reset: all outputs 0; per-digit last-pattern regs 0, stability counts 0, seen mask 0.
//  - All outputs registered; response appears the cycle after the sample_en cycle.
//  - sample_en=1, an_in one-hot at k: if seg_in == last[k], count[k] += 1, saturating at STABLE_CNT;
//    else last[k] <= seg_in, count[k] <= 1. No effect on other digits.
//  - Acceptance fires only on the sample where count[k] reaches STABLE_CNT (not again while saturated).
//    STABLE_CNT=1: every sample whose pattern differs from last[k], plus the first sample after reset.
//  - Legal table (hex of seg_in -> value): 7E->0 30->1 6D->2 79->3 33->4 5B->5 5F->6 70->7
//    7F->8 7B->9 77->A 1F->b 4E->C 3D->d 4F->E 47->F. Anything else is illegal.
//  - Accept legal: digit_data[k] <= value, digit_valid[k] <= 1, seen[k] <= 1.
//  - Accept illegal: pattern_err pulses, digit_valid[k] <= 0, digit_data[k] held, seen[k] unchanged.
//  - Pattern change before acceptance: digit_data[k]/digit_valid[k] hold previous accepted value.
//  - an_in zero or multi-hot with sample_en: sample discarded, no state change, an_err pulses.
//  - sample_en=0: no state change; all pulse outputs 0.
//  - frame_valid: pulses the cycle seen becomes all-ones (incl. the accepting sample);
//    seen clears to 0 in the same update. Accepted-digit order is irrelevant.
//  - Reset asserted mid-frame: immediate return to reset values; partial frame discarded.
//  - Counter width: $clog2(STABLE_CNT+1); digit index width: $clog2(DIGITS), min 1.
// CONFIGURATION
//  SEG7_BLANK_DETECT_EN defined: seg_in=00 accepted as blank - digit_valid[k] <= 0, seen[k] <= 1,
//    no pattern_err; digit_data[k] held.
//  Not defined: 00 is an ordinary illegal pattern (pattern_err pulses, seen[k] unchanged).
// TESTING
//  1 Reset low mid-run -> all outputs 0 same cycle; after release, 3 samples digit0=7E -> digit_data[3:0]=0, valid[0]=1.
//  2 Scan digits 0..3 with 30,6D,79,33, 3 samples each -> digit_data=16'h4321, valid=4'hF, one frame_valid pulse.
//  3 Digit1: 7E,7E,30,30,30 -> no accept until 5th sample, then value 1; after 7E,7E only, value 1 held.
//  4 Digit2 stable 3x 55 -> pattern_err one pulse, valid[2]=0, data held; 4th 55 -> no further pulse.
//  5 sample_en with an_in=0000 and 0011 -> an_err pulses each time, counts/data unchanged.
//  6 Digit3 stable 3x 00 -> with SEG7_BLANK_DETECT_EN: valid[3]=0, no error; without: pattern_err pulse.

Source files
------------

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder
//   Receive side of the multiplexed 7-segment display path. The block samples the
//   scanned segment/anode lines and debounces each digit separately. It decodes
//   every accepted segment pattern back to a hex value and flags patterns that
//   are not legal hex glyphs.
//   Optional feature: define SEG7_BLANK_DETECT_EN to treat an all-off pattern
//   (seg_in == 7'h00) as a legal blank digit instead of an illegal pattern.
module seg7_scan_decoder #(
    parameter int DIGITS     = 4,   // scanned digits, 1..8
    parameter int STABLE_CNT = 3    // identical samples needed for acceptance, 1..15
) (
    input  logic                clk,
    input  logic                reset,        // asynchronous, active-low
    input  logic                sample_en,
    input  logic [6:0]          seg_in,       // {a,b,c,d,e,f,g}
    input  logic [DIGITS-1:0]   an_in,        // one-hot digit select
    output logic [4*DIGITS-1:0] digit_data,
    output logic [DIGITS-1:0]   digit_valid,
    output logic                frame_valid,
    output logic                pattern_err,
    output logic                an_err
);

    localparam int CW = $clog2(STABLE_CNT + 1);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CNT);

    typedef struct packed {
        logic       legal;
        logic [3:0] value;
    } seg_dec_t;

    // Segment glyph to hex value; anything outside the 16 glyphs is illegal.
    function automatic seg_dec_t decode_seg(input logic [6:0] seg);
        seg_dec_t d;
        d.legal = 1'b1;
        d.value = 4'h0;
        case (seg)
            7'h7E:   d.value = 4'h0;
            7'h30:   d.value = 4'h1;
            7'h6D:   d.value = 4'h2;
            7'h79:   d.value = 4'h3;
            7'h33:   d.value = 4'h4;
            7'h5B:   d.value = 4'h5;
            7'h5F:   d.value = 4'h6;
            7'h70:   d.value = 4'h7;
            7'h7F:   d.value = 4'h8;
            7'h7B:   d.value = 4'h9;
            7'h77:   d.value = 4'hA;
            7'h1F:   d.value = 4'hB;
            7'h4E:   d.value = 4'hC;
            7'h3D:   d.value = 4'hD;
            7'h4F:   d.value = 4'hE;
            7'h47:   d.value = 4'hF;
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

    // Per-digit debounce state.
    logic [6:0]        last_q  [DIGITS];
    logic [CW-1:0]     count_q [DIGITS];
    logic [DIGITS-1:0] seen_q;

    logic              an_onehot;
    logic              take;
    logic [IW-1:0]     sel;
    logic [6:0]        sel_last;
    logic [CW-1:0]     sel_cnt;
    logic              match;
    logic              cnt_sat;
    logic [CW-1:0]     cnt_next;
    logic              accept;
    seg_dec_t          dec;
    logic              is_blank;
    logic              acc_legal;
    logic              acc_illegal;
    logic              acc_blank;
    logic [DIGITS-1:0] seen_next;
    logic              frame_done;

`ifdef SEG7_BLANK_DETECT_EN
    assign is_blank = (seg_in == 7'h00);
`else
    assign is_blank = 1'b0;
`endif

    // Exactly one anode active; zero or multi-hot samples are discarded.
    assign an_onehot = (an_in != '0) && ((an_in & (an_in - DIGITS'(1))) == '0);
    assign take      = sample_en & an_onehot;

    // Encode the active anode into a digit index.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        sel = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (an_in[i]) sel = IW'(i);
        end
    end

    // Stability counting and acceptance decision for the selected digit.
    always_comb begin
        sel_last = last_q[sel];
        sel_cnt  = count_q[sel];
        match    = (seg_in == sel_last);
        cnt_sat  = (sel_cnt == CNT_MAX);
        cnt_next = CW'(1);
        accept   = 1'b0;
        if (match) begin
            // Saturate so a held pattern is accepted once, not on every sample.
            cnt_next = cnt_sat ? sel_cnt : sel_cnt + CW'(1);
            accept   = !cnt_sat && ((sel_cnt + CW'(1)) == CNT_MAX);
        end else begin
            accept   = (STABLE_CNT == 1);
        end
        dec         = decode_seg(seg_in);
        acc_legal   = take & accept & dec.legal;
        acc_blank   = take & accept & is_blank;
        acc_illegal = take & accept & ~dec.legal & ~is_blank;
        seen_next   = seen_q | ((acc_legal | acc_blank) ? an_in : '0);
        frame_done  = take & (&seen_next);
    end

    // State and registered outputs; pulse outputs default low each cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the debounce arrays are only DIGITS entries of flops, so they are reset like any other state.
            for (int i = 0; i < DIGITS; i++) begin
                last_q[i]  <= '0;
                count_q[i] <= '0;
            end
            seen_q      <= '0;
            digit_data  <= '0;
            digit_valid <= '0;
            frame_valid <= 1'b0;
            pattern_err <= 1'b0;
            an_err      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples pre-edge values.
            an_err      <= sample_en & ~an_onehot;
            pattern_err <= acc_illegal;
            frame_valid <= frame_done;
            if (take) begin
                last_q[sel]  <= seg_in;
                count_q[sel] <= cnt_next;
                seen_q       <= frame_done ? '0 : seen_next;
            end
            if (acc_legal) begin
                digit_data[4*sel +: 4] <= dec.value;
                digit_valid[sel]       <= 1'b1;
            end
            if (acc_illegal | acc_blank) begin
                digit_valid[sel] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder
//   Scoreboard bench for seg7_scan_decoder (DIGITS=4, STABLE_CNT=3). Each sample
//   step pushes the reference-model prediction into a queue. The prediction is
//   popped and compared one clock later. Scenario tasks add direct checks.
//   Build with SEG7_BLANK_DETECT_EN to exercise the blank-digit variant.
module tb_seg7_scan_decoder;

    localparam int DIGITS     = 4;
    localparam int STABLE_CNT = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_en;
    logic [6:0]  seg_in;
    logic [3:0]  an_in;
    logic [15:0] digit_data;
    logic [3:0]  digit_valid;
    logic        frame_valid;
    logic        pattern_err;
    logic        an_err;

    seg7_scan_decoder #(.DIGITS(DIGITS), .STABLE_CNT(STABLE_CNT)) dut (
        .clk         (clk),
        .reset       (reset),
        .sample_en   (sample_en),
        .seg_in      (seg_in),
        .an_in       (an_in),
        .digit_data  (digit_data),
        .digit_valid (digit_valid),
        .frame_valid (frame_valid),
        .pattern_err (pattern_err),
        .an_err      (an_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  valid;
        logic        frame;
        logic        perr;
        logic        anerr;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   frame_cnt = 0;
    int   perr_cnt = 0;

    // Reference model state.
    logic [6:0]  m_last [4];
    int          m_cnt  [4];
    logic [15:0] m_data;
    logic [3:0]  m_valid;
    logic [3:0]  m_seen;
    logic [6:0]  seg_tab [16];

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_last[i] = 7'h00;
            m_cnt[i]  = 0;
        end
        m_data  = '0;
        m_valid = '0;
        m_seen  = '0;
        exp_q.delete();
    endtask

    // Prediction of the outputs that follow one sample cycle.
    task automatic model_sample(input logic en, input logic [6:0] seg, input logic [3:0] an,
                                output obs_t e);
        int k;
        int v;
        bit acc;
        e   = '0;
        k   = 0;
        v   = -1;
        acc = 0;
        if (en) begin
            if ($countones(an) != 1) begin
                e.anerr = 1'b1;
            end else begin
                for (int i = 0; i < 4; i++) if (an[i]) k = i;
                if (seg == m_last[k]) begin
                    if (m_cnt[k] < STABLE_CNT) begin
                        m_cnt[k] = m_cnt[k] + 1;
                        acc = (m_cnt[k] == STABLE_CNT);
                    end
                end else begin
                    m_last[k] = seg;
                    m_cnt[k]  = 1;
                    acc = (STABLE_CNT == 1);
                end
                if (acc) begin
                    for (int j = 0; j < 16; j++) if (seg_tab[j] == seg) v = j;
                    if (v >= 0) begin
                        m_data[4*k +: 4] = v[3:0];
                        m_valid[k] = 1'b1;
                        m_seen[k]  = 1'b1;
                    end
`ifdef SEG7_BLANK_DETECT_EN
                    else if (seg == 7'h00) begin
                        m_valid[k] = 1'b0;
                        m_seen[k]  = 1'b1;
                    end
`endif
                    else begin
                        e.perr     = 1'b1;
                        m_valid[k] = 1'b0;
                    end
                    if (m_seen == 4'hF) begin
                        e.frame = 1'b1;
                        m_seen  = '0;
                    end
                end
            end
        end
        e.data  = m_data;
        e.valid = m_valid;
    endtask

    // One sample cycle: drive, predict, then compare the registered response.
    task automatic step(input logic en, input logic [6:0] seg, input logic [3:0] an);
        obs_t e;
        obs_t got;
        @(negedge clk);
        sample_en = en;
        seg_in    = seg;
        an_in     = an;
        model_sample(en, seg, an, e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = {digit_data, digit_valid, frame_valid, pattern_err, an_err};
        if (got.frame) frame_cnt++;
        if (got.perr) perr_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty got data=%h valid=%b", got.data, got.valid);
        end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
                errors++;
                $display("FAIL sample en=%b seg=%h an=%b: got data=%h valid=%b frame=%b perr=%b anerr=%b, want data=%h valid=%b frame=%b perr=%b anerr=%b",
                         en, seg, an, got.data, got.valid, got.frame, got.perr, got.anerr,
                         e.data, e.valid, e.frame, e.perr, e.anerr);
            end
        end
        sample_en = 1'b0;
    endtask

    task automatic repeat_step(input int n, input logic [6:0] seg, input logic [3:0] an);
        for (int i = 0; i < n; i++) step(1'b1, seg, an);
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        sample_en = 1'b0;
        seg_in    = '0;
        an_in     = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({digit_data, digit_valid, frame_valid, pattern_err, an_err} !== 23'h0) begin
            errors++;
            $display("FAIL reset_state got data=%h valid=%b frame=%b perr=%b anerr=%b want all 0",
                     digit_data, digit_valid, frame_valid, pattern_err, an_err);
        end
        @(negedge clk);
        reset = 1'b1;
        // Partial frame: digits 0..2 accepted, then reset mid-run.
        repeat_step(3, 7'h30, 4'b0001);
        repeat_step(3, 7'h6D, 4'b0010);
        repeat_step(3, 7'h79, 4'b0100);
        step(1'b1, 7'h33, 4'b1000);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if ({digit_data, digit_valid, frame_valid, pattern_err, an_err} !== 23'h0) begin
            errors++;
            $display("FAIL reset_midrun got data=%h valid=%b want 0 before next edge",
                     digit_data, digit_valid);
        end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat_step(2, 7'h7E, 4'b0001);
        checks++;
        if (digit_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_two_samples got valid0=%b want 0", digit_valid[0]);
        end
        step(1'b1, 7'h7E, 4'b0001);
        checks++;
        if (digit_data[3:0] !== 4'h0 || digit_valid[0] !== 1'b1) begin
            errors++;
            $display("FAIL reset_accept got d0=%h valid0=%b want 0 1", digit_data[3:0], digit_valid[0]);
        end
    endtask

    task automatic test_scan();
        logic [6:0] pats [4];
        pats = '{7'h30, 7'h6D, 7'h79, 7'h33};
        frame_cnt = 0;
        for (int d = 0; d < 4; d++) repeat_step(3, pats[d], 4'b0001 << d);
        checks++;
        if (digit_data !== 16'h4321 || digit_valid !== 4'hF) begin
            errors++;
            $display("FAIL scan_values got data=%h valid=%h want 4321 F", digit_data, digit_valid);
        end
        checks++;
        if (frame_cnt !== 1) begin
            errors++;
            $display("FAIL scan_frame got %0d pulses want 1", frame_cnt);
        end
    endtask

    task automatic test_change_before_accept();
        repeat_step(2, 7'h7E, 4'b0010);
        repeat_step(2, 7'h30, 4'b0010);
        checks++;
        if (digit_data[7:4] !== 4'h2 || digit_valid[1] !== 1'b1) begin
            errors++;
            $display("FAIL change_hold got d1=%h valid1=%b want 2 1", digit_data[7:4], digit_valid[1]);
        end
        step(1'b1, 7'h30, 4'b0010);
        checks++;
        if (digit_data[7:4] !== 4'h1) begin
            errors++;
            $display("FAIL change_accept got d1=%h want 1", digit_data[7:4]);
        end
        repeat_step(2, 7'h7E, 4'b0010);
        checks++;
        if (digit_data[7:4] !== 4'h1 || digit_valid[1] !== 1'b1) begin
            errors++;
            $display("FAIL change_short_run got d1=%h valid1=%b want 1 1", digit_data[7:4], digit_valid[1]);
        end
    endtask

    task automatic test_illegal();
        perr_cnt = 0;
        repeat_step(3, 7'h55, 4'b0100);
        checks++;
        if (perr_cnt !== 1 || digit_valid[2] !== 1'b0 || digit_data[11:8] !== 4'h3) begin
            errors++;
            $display("FAIL illegal_accept got perr=%0d valid2=%b d2=%h want 1 0 3",
                     perr_cnt, digit_valid[2], digit_data[11:8]);
        end
        step(1'b1, 7'h55, 4'b0100);
        checks++;
        if (perr_cnt !== 1) begin
            errors++;
            $display("FAIL illegal_saturated got %0d pulses want 1", perr_cnt);
        end
    endtask

    task automatic test_an_err();
        logic [15:0] d0;
        logic [3:0]  v0;
        d0 = digit_data;
        v0 = digit_valid;
        step(1'b1, 7'h7E, 4'b0000);
        checks++;
        if (an_err !== 1'b1) begin
            errors++;
            $display("FAIL an_err_zero got %b want 1", an_err);
        end
        step(1'b1, 7'h7E, 4'b0011);
        checks++;
        if (an_err !== 1'b1) begin
            errors++;
            $display("FAIL an_err_multi got %b want 1", an_err);
        end
        step(1'b0, 7'h4F, 4'b0001);
        checks++;
        if (an_err !== 1'b0 || digit_data !== d0 || digit_valid !== v0) begin
            errors++;
            $display("FAIL an_err_nochange got anerr=%b data=%h valid=%h want 0 %h %h",
                     an_err, digit_data, digit_valid, d0, v0);
        end
        // Digit 0 still holds 30 saturated: one more 30 must not re-accept.
        step(1'b1, 7'h30, 4'b0001);
    endtask

    task automatic test_blank();
        perr_cnt = 0;
        repeat_step(3, 7'h00, 4'b1000);
        checks++;
`ifdef SEG7_BLANK_DETECT_EN
        if (perr_cnt !== 0 || digit_valid[3] !== 1'b0 || digit_data[15:12] !== 4'h4) begin
            errors++;
            $display("FAIL blank_accept got perr=%0d valid3=%b d3=%h want 0 0 4",
                     perr_cnt, digit_valid[3], digit_data[15:12]);
        end
`else
        if (perr_cnt !== 1 || digit_valid[3] !== 1'b0 || digit_data[15:12] !== 4'h4) begin
            errors++;
            $display("FAIL blank_illegal got perr=%0d valid3=%b d3=%h want 1 0 4",
                     perr_cnt, digit_valid[3], digit_data[15:12]);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic [6:0] pool [6];
        logic [6:0] cur;
        logic [3:0] an;
        pool = '{7'h7E, 7'h30, 7'h6D, 7'h55, 7'h00, 7'h4F};
        cur  = 7'h7E;
        an   = 4'b0001;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) cur = pool[$urandom_range(0, 5)];
            if ($urandom_range(0, 2) == 0) an = 4'b0001 << $urandom_range(0, 3);
            if ($urandom_range(0, 11) == 0)
                step(1'b1, cur, ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'b0110);
            else
                step($urandom_range(0, 9) != 0, cur, an);
        end
    endtask

    initial begin
        seg_tab = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
        test_reset();
        test_scan();
        test_change_before_accept();
        test_illegal();
        test_an_err();
        test_blank();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got %0d entries want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
